// File: rtl/rr_encoder8_3_if.sv
// Request/handshake bundle for the round-robin 8-to-3 encoder.
// The slave side is the encoder; the master side drives requests and ready.
interface rr_encoder8_3_if;
  logic       enable;
  logic [7:0] req;
  logic       ready;
  logic       valid;
  logic [2:0] code;
  logic [7:0] pending;
  logic       busy;

  modport master (
    output enable, req, ready,
    input  valid, code, pending, busy
  );

  modport slave (
    input  enable, req, ready,
    output valid, code, pending, busy
  );
endinterface

// File: rtl/rr_encoder8_3.sv
// Registered round-robin 8-to-3 encoder: captures request strobes into a pending
// set and emits one pending line index per valid/ready handshake.
module rr_encoder8_3 (
  input  logic           clk,
  input  logic           reset_n,
  rr_encoder8_3_if.slave bus
);

  logic [7:0] pending_q, pending_d;
  logic       valid_q, valid_d;
  logic [2:0] code_q, code_d;
  logic [2:0] ptr_q, ptr_d;

  logic [7:0] effReq;
  logic       slotFree;
  logic       selFound;
  logic [2:0] selIdx;
  logic [2:0] probeIdx;
  logic       loaded;

  assign effReq   = pending_q | (bus.req & {8{bus.enable}});
  assign slotFree = !valid_q || bus.ready;

  // Search starts one past the last loaded index; the eighth probe lands back on ptr itself.
  always_comb begin
    selFound = 1'b0;
    selIdx   = ptr_q;
    probeIdx = ptr_q;
    for (int i = 1; i <= 8; i++) begin
      probeIdx = ptr_q + 3'(i);
      if (!selFound && effReq[probeIdx]) begin
        selFound = 1'b1;
        selIdx   = probeIdx;
      end
    end
  end

  assign loaded = slotFree && selFound;

  always_comb begin
    valid_d   = valid_q;
    code_d    = code_q;
    ptr_d     = ptr_q;
    pending_d = effReq;
    if (slotFree) begin
      valid_d = selFound;
      if (selFound) begin
        code_d = selIdx;
        ptr_d  = selIdx;
      end
    end
    // A line leaves the pending set when it is loaded, not when it is accepted.
    if (loaded) begin
      pending_d = effReq & ~(8'b1 << selIdx);
    end
  end

  // Reset value of ptr makes the first search after reset begin at line 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 8'h00;
      valid_q   <= 1'b0;
      code_q    <= 3'd0;
      ptr_q     <= 3'd7;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.valid   = valid_q;
  assign bus.code    = code_q;
  assign bus.pending = pending_q;
  assign bus.busy    = valid_q | (|pending_q);

endmodule
